// File: rtl/mips_mmio_if.sv
// Data-side bus between the single-cycle mips core and the mmio block, plus the tx drain port.
// The master side is the core and tx sink. The slave side is mips_mmio.
interface mips_mmio_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        timer_irq;

    modport master (
        output memwrite, aluout, writedata, tx_ready,
        input  readdata, tx_valid, tx_data, timer_irq
    );

    modport slave (
        input  memwrite, aluout, writedata, tx_ready,
        output readdata, tx_valid, tx_data, timer_irq
    );
endinterface

// File: rtl/mips_mmio.sv
// Data RAM, compare timer and tx FIFO behind the core's data port. Loads take 0 cycles; stores take 1 edge.
// The tx FIFO drains on valid/ready. A push into a full FIFO is dropped and sets the sticky overflow bit.
module mips_mmio #(
    parameter int DMEM_WORDS = 64,
    parameter int TX_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    mips_mmio_if.slave io_bus
);
    localparam int          AW       = $clog2(DMEM_WORDS);
    localparam int          PW       = $clog2(TX_DEPTH);
    localparam logic [3:0]  DEPTH    = 4'(TX_DEPTH);
    localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_0014;

    logic [31:0]   r_dmem [DMEM_WORDS];
    logic [31:0]   r_tcount;
    logic [31:0]   r_tcmp;
    logic          r_en;
    logic          r_flag;
    logic [31:0]   r_fifo [TX_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [3:0]    r_count;
    logic          r_ovf;

    logic [31:0]   w_addr;
    logic          w_ram_sel;
    logic [AW-1:0] w_widx;
    logic          w_wr_tcount, w_wr_tcmp, w_wr_tctrl, w_wr_txdata, w_wr_txstat;
    logic          w_full, w_push, w_pop, w_match;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_addr      = {io_bus.aluout[31:2], 2'b00};
    // Address bits between the RAM index and bit 16 alias onto the same words.
    assign w_ram_sel   = (io_bus.aluout[31:16] == 16'h0000);
    assign w_widx      = io_bus.aluout[AW+1:2];
    assign w_wr_tcount = io_bus.memwrite && (w_addr == A_TCOUNT);
    assign w_wr_tcmp   = io_bus.memwrite && (w_addr == A_TCMP);
    assign w_wr_tctrl  = io_bus.memwrite && (w_addr == A_TCTRL);
    assign w_wr_txdata = io_bus.memwrite && (w_addr == A_TXDATA);
    assign w_wr_txstat = io_bus.memwrite && (w_addr == A_TXSTAT);
    assign w_full      = (r_count == DEPTH);
    assign w_push      = w_wr_txdata && !w_full;
    assign w_pop       = (r_count != 4'd0) && io_bus.tx_ready;
    assign w_match     = r_en && (r_tcount == r_tcmp);
    assign w_unused    = &{1'b0, io_bus.aluout};

    always_ff @(posedge i_clk) begin
        if (io_bus.memwrite && w_ram_sel) begin
            r_dmem[w_widx] <= io_bus.writedata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tcount <= '0;
            r_tcmp   <= '0;
            r_en     <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            if (w_wr_tcount) begin
                r_tcount <= io_bus.writedata;
            end else if (r_en) begin
                r_tcount <= r_tcount + 32'd1;
            end
            if (w_wr_tcmp) begin
                r_tcmp <= io_bus.writedata;
            end
            if (w_wr_tctrl) begin
                r_en <= io_bus.writedata[0];
            end
            // A match on this edge beats a software clear on the same edge.
            if (w_match) begin
                r_flag <= 1'b1;
            end else if (w_wr_tctrl && io_bus.writedata[1]) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= io_bus.writedata;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
            if (w_wr_txdata && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_txstat && io_bus.writedata[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_dmem[w_widx];
        end else begin
            case (w_addr)
                A_TCOUNT: w_rdata = r_tcount;
                A_TCMP:   w_rdata = r_tcmp;
                A_TCTRL:  w_rdata = {30'd0, r_flag, r_en};
                A_TXSTAT: w_rdata = {24'd0, r_count, 1'b0, r_ovf, (r_count == 4'd0), w_full};
                default:  w_rdata = '0;
            endcase
        end
    end

    assign io_bus.readdata  = w_rdata;
    assign io_bus.tx_valid  = (r_count != 4'd0);
    assign io_bus.tx_data   = r_fifo[r_rd_ptr];
    assign io_bus.timer_irq = r_flag;
endmodule

// File: doc/mips_mmio.md
# mips_mmio

Memory-mapped data-side subsystem that sits directly downstream of the single-cycle `mips` core. It consumes the core's `memwrite`, `aluout` (address) and `writedata`, and returns `readdata` in the same cycle. It contains a word-addressed data RAM, a 32-bit compare timer with an interrupt flag, and a transmit FIFO drained through a valid/ready port.

## Interface
- `DMEM_WORDS`, 64: data RAM depth in 32-bit words; power of 2, at most 16384.
- `TX_DEPTH`, 4: transmit FIFO depth; one of 2, 4, 8.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe from the core.
- `aluout`  in  32  byte address from the core; bits [1:0] are ignored.
- `writedata`  in  32  store data from the core.
- `readdata`  out  32  load data; combinational from `aluout`.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_data`  out  32  FIFO head entry.
- `tx_ready`  in  1  sink accepts the head entry.
- `timer_irq`  out  1  timer match flag.

## Operation
Address map (word aligned; any address not listed reads 0, and writes to it are ignored):
- RAM: `aluout[31:16]==0` and word index `aluout[AW+1:2] < DMEM_WORDS`, where AW = log2(DMEM_WORDS). Bits in the gap are ignored.
  - Read is asynchronous. Write happens at the edge when `memwrite=1`.
  - RAM contents are not reset.
- 0xFFFF_0000 TCOUNT (RW): timer counter.
- 0xFFFF_0004 TCMP (RW): compare value.
- 0xFFFF_0008 TCTRL:
  - bit0 enable (RW).
  - bit1 match flag (read; write 1 to clear).
  - Other bits read 0.
- 0xFFFF_0010 TXDATA (W): pushes `writedata` into the FIFO. Reads return 0.
- 0xFFFF_0014 TXSTAT:
  - bit0 full, bit1 empty, bit2 overflow (sticky; write 1 to clear), bits[7:4] count.
  - Other bits read 0.

Timer:
- At each edge with enable=1, TCOUNT increments by 1 and wraps from 0xFFFF_FFFF to 0.
- A TCOUNT write in the same cycle overrides the increment and loads `writedata`.
- Match: at an edge where enable=1 and the pre-edge TCOUNT equals TCMP, the flag is set.
- Set wins over a same-cycle W1C clear.
- `timer_irq` equals the flag.

FIFO:
- Circular buffer: read and write pointers plus a count.
- `tx_valid = (count != 0)`. `tx_data` is the head entry; it is the storage value, 0 after reset.
- Push: TXDATA write when the pre-edge count < TX_DEPTH.
- A push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- Pop: `tx_valid && tx_ready` at an edge.
- Push and pop in the same cycle when not full: count is unchanged and both pointers advance.

Reset (asynchronous assert, released on the rising edge of `reset`):
- TCOUNT, TCMP, enable, flag, pointers, count, overflow and FIFO storage all go to 0.
- Outputs during reset: `tx_valid=0`, `tx_data=0`, `timer_irq=0`.
- `readdata` still follows the address map; registers read 0.
- Reset asserted mid-operation discards FIFO contents. RAM contents are retained.

## Timing
- Load latency is 0 cycles: `readdata` is valid in the same cycle that `aluout` is presented, as the single-cycle core requires.
- Store latency is 1 edge: a read of the same address in the next cycle returns the new value.
- A TXDATA push is visible on `tx_valid`/`tx_data` after the edge. An entry pushed into an empty FIFO can be popped at the next edge.
- TXSTAT and TCTRL reads reflect pre-edge state.
- The flag sets at the edge where pre-edge TCOUNT == TCMP. `timer_irq` rises immediately after that edge.

## Test plan
- RAM: with `memwrite=1`, write 0xDEADBEEF to 0x04 and 0xCAFEBABE to 0xFC. Then read 0x04, 0xFC and 0x08. Expected: DEADBEEF, CAFEBABE, and 0x08 unchanged. Reading 0x1000_0000 returns 0.
- Timer:
  - Write TCMP=5, then TCTRL=1. Expected: TCOUNT reads 1, 2, … on successive cycles, and `timer_irq` rises after the edge where the count was 5.
  - Write TCTRL=0x2. Expected: flag clears.
  - Write TCOUNT=0xFFFF_FFFF with enable=1. Expected: TCOUNT wraps to 0.
- FIFO fill with `tx_ready=0`: push 1..5. Expected: TXSTAT = full, count 4, overflow=1; `tx_data=1`. Then write TXSTAT=0x4. Expected: overflow clears.
- FIFO drain: raise `tx_ready`. Expected: entries 1, 2, 3, 4 out on consecutive cycles, then `tx_valid=0`, TXSTAT empty. Push while full with `tx_ready=1`. Expected: push dropped, one entry popped.
- Reset: pulse `reset` low for 3 ns mid-drain, asynchronously between edges. Expected: `tx_valid`, `timer_irq`, TCOUNT all 0 immediately, with RAM contents at 0x04 intact.
